// File: rtl/uart_stream_core.sv
// Full-duplex UART with valid/ready byte streams, RTS/CTS flow control and RX error reporting.
// Optional parity bit is compiled in when UART_PARITY_EN is defined.
module uart_stream_core #(
  parameter int BIT_CLK    = 8,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 cts,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rts,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_overrun
);

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam int            TW      = $clog2(BIT_CLK);
  localparam logic [TW-1:0] T_LAST  = TW'(BIT_CLK - 1);
  localparam logic [TW-1:0] T_PRE   = TW'(BIT_CLK - 2);
  localparam logic [TW-1:0] T_MID   = TW'(BIT_CLK / 2);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [3:0]    B_LAST  = 4'(DATA_BITS - 1);
  localparam logic          S_LAST  = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 tx_state, tx_state_n;
  logic [TW-1:0]          tx_timer, tx_timer_n;
  logic [3:0]             tx_bits, tx_bits_n;
  logic                   tx_stop, tx_stop_n;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
  logic                   tx_par, tx_par_n;
  logic                   txd_n;
  logic                   tx_wrap;

  assign tx_ready = (tx_state == IDLE) && cts;
  assign tx_wrap  = (tx_timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_timer <= '0;
      tx_bits  <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_timer <= tx_timer_n;
      tx_bits  <= tx_bits_n;
      tx_stop  <= tx_stop_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      txd      <= txd_n;
    end
  end

  // The final stop bit is one cycle short in STOP; the IDLE cycle that follows
  // supplies its last high cycle, so a held tx_valid restarts with no gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_wrap ? '0 : tx_timer + 1'b1;
    tx_bits_n  = tx_bits;
    tx_stop_n  = tx_stop;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    case (tx_state)
      IDLE: begin
        tx_timer_n = '0;
        if (tx_valid && tx_ready) begin
          tx_state_n = START;
          tx_shift_n = tx_data;
          tx_par_n   = (^tx_data) ^ PAR_ODD;
        end
      end
      START: begin
        if (tx_wrap) begin
          tx_state_n = DATA;
          tx_bits_n  = '0;
        end
      end
      DATA: begin
        if (tx_wrap) begin
          if (tx_bits == B_LAST) begin
            tx_state_n = PAR_EN ? PARITY : STOP;
            tx_stop_n  = 1'b0;
          end else begin
            tx_shift_n = tx_shift >> 1;
            tx_bits_n  = tx_bits + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tx_wrap) begin
          tx_state_n = STOP;
          tx_stop_n  = 1'b0;
        end
      end
      STOP: begin
        if (tx_stop == S_LAST && tx_timer == T_PRE) begin
          tx_state_n = IDLE;
          tx_timer_n = '0;
        end else if (tx_wrap) begin
          tx_stop_n = tx_stop + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
    case (tx_state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tx_shift_n[0];
      PARITY:  txd_n = tx_par_n;
      default: txd_n = 1'b1;
    endcase
  end

  // Stage p0/p1: two-flop synchroniser; p2 is the previous synchronised level for edge detect
  logic rxd_p0, rxd_p1, rxd_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  state_t               rx_state, rx_state_n;
  logic [TW-1:0]        rx_timer, rx_timer_n;
  logic [3:0]           rx_bits, rx_bits_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_perr, rx_perr_n;
  logic                 rx_ferr, rx_ferr_n;
  logic                 rx_done, rx_done_n;
  logic                 rx_mid;

  assign rx_mid = (rx_timer == T_MID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= IDLE;
      rx_timer <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_done  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_timer <= rx_timer_n;
      rx_bits  <= rx_bits_n;
      rx_shift <= rx_shift_n;
      rx_perr  <= rx_perr_n;
      rx_ferr  <= rx_ferr_n;
      rx_done  <= rx_done_n;
    end
  end

  // The edge-detect cycle counts as timer 0, so START is entered at timer 1.
  always_comb begin
    rx_state_n = rx_state;
    rx_timer_n = (rx_timer == T_LAST) ? '0 : rx_timer + 1'b1;
    rx_bits_n  = rx_bits;
    rx_shift_n = rx_shift;
    rx_perr_n  = rx_perr;
    rx_ferr_n  = rx_ferr;
    rx_done_n  = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_timer_n = '0;
        if (rxd_p2 && !rxd_p1) begin
          rx_state_n = START;
          rx_timer_n = T_ONE;
          rx_perr_n  = 1'b0;
        end
      end
      START: begin
        if (rx_mid) begin
          rx_state_n = rxd_p1 ? IDLE : DATA;
          rx_bits_n  = '0;
        end
      end
      DATA: begin
        if (rx_mid) begin
          rx_shift_n = {rxd_p1, rx_shift[DATA_BITS-1:1]};
          if (rx_bits == B_LAST) rx_state_n = PAR_EN ? PARITY : STOP;
          else                   rx_bits_n  = rx_bits + 1'b1;
        end
      end
      PARITY: begin
        if (rx_mid) begin
          rx_perr_n  = ((^rx_shift) ^ PAR_ODD) != rxd_p1;
          rx_state_n = STOP;
        end
      end
      STOP: begin
        if (rx_mid) begin
          rx_done_n  = 1'b1;
          rx_ferr_n  = !rxd_p1;
          rx_state_n = IDLE;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // Holding register: a completed frame loads only if the slot is empty or being popped now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= rx_shift;
          frame_err  <= rx_ferr;
          parity_err <= PAR_EN & rx_perr;
          rx_valid   <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end

  assign rts = !rx_valid;

endmodule

// File: tb/tb_uart_stream_core.sv
// Bench for uart_stream_core: two cross-connected instances plus a bench-driven serial line
// and an independent serial decoder on the u1 transmit line.
module tb_uart_stream_core;

`ifdef UART_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int BC = 8;
  localparam int NB = 1 + 8 + PEN + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] u1_tx_data, u2_tx_data, u1_rx_data, u2_rx_data;
  logic u1_tx_valid, u1_tx_ready, u1_cts, u1_txd, u1_rxd, u1_rx_valid, u1_rx_ready;
  logic u1_rts, u1_frame_err, u1_parity_err, u1_rx_overrun;
  logic u2_tx_valid, u2_tx_ready, u2_cts, u2_txd, u2_rxd, u2_rx_valid, u2_rx_ready;
  logic u2_rts, u2_frame_err, u2_parity_err, u2_rx_overrun;
  logic cts_force, drv_en, drv_line;

  assign u1_cts = cts_force | u2_rts;
  assign u2_cts = u1_rts;
  assign u2_rxd = drv_en ? drv_line : u1_txd;
  assign u1_rxd = u2_txd;

  uart_stream_core #(.BIT_CLK(BC), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(u1_tx_data), .tx_valid(u1_tx_valid), .tx_ready(u1_tx_ready),
    .cts(u1_cts), .txd(u1_txd), .rxd(u1_rxd), .rx_data(u1_rx_data), .rx_valid(u1_rx_valid),
    .rx_ready(u1_rx_ready), .rts(u1_rts), .frame_err(u1_frame_err), .parity_err(u1_parity_err),
    .rx_overrun(u1_rx_overrun));

  uart_stream_core #(.BIT_CLK(BC), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(u2_tx_data), .tx_valid(u2_tx_valid), .tx_ready(u2_tx_ready),
    .cts(u2_cts), .txd(u2_txd), .rxd(u2_rxd), .rx_data(u2_rx_data), .rx_valid(u2_rx_valid),
    .rx_ready(u2_rx_ready), .rts(u2_rts), .frame_err(u2_frame_err), .parity_err(u2_parity_err),
    .rx_overrun(u2_rx_overrun));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_pulses = 0, ov_cycles = 0;
  logic ov_prev = 1'b0, txd_prev = 1'b1, rxv_prev = 1'b0, dec_prev = 1'b1;
  logic dec_en = 1'b1;
  logic [9:0] got[$];     // {frame_err, parity_err, data} popped from u2
  logic [7:0] got1[$];    // bytes popped from u1
  logic [8:0] tx_seen[$]; // {framing/parity error, data} decoded from u1 txd
  int acc[$], fall[$], rise[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Passive observers, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (u2_rx_valid && u2_rx_ready) got.push_back({u2_frame_err, u2_parity_err, u2_rx_data});
    if (u1_rx_valid && u1_rx_ready) got1.push_back(u1_rx_data);
    if (u2_rx_overrun) begin
      ov_cycles++;
      if (!ov_prev) ov_pulses++;
    end
    if (u1_tx_valid && u1_tx_ready) acc.push_back(cyc);
    if (txd_prev && !u1_txd) fall.push_back(cyc);
    if (!rxv_prev && u2_rx_valid) rise.push_back(cyc);
    ov_prev  = u2_rx_overrun;
    txd_prev = u1_txd;
    rxv_prev = u2_rx_valid;
  end

  // Reference serial decoder: samples u1 txd at the centre of every bit of a frame
  always begin
    logic [7:0] d;
    logic bad;
    @(negedge clk);
    if (dec_en && dec_prev && !u1_txd) begin
      repeat (BC / 2) @(negedge clk);
      bad = (u1_txd !== 1'b0);
      for (int j = 0; j < 8; j++) begin
        repeat (BC) @(negedge clk);
        d[j] = u1_txd;
      end
      if (PEN == 1) begin
        repeat (BC) @(negedge clk);
        if (u1_txd !== ^d) bad = 1'b1;
      end
      repeat (BC) @(negedge clk);
      if (u1_txd !== 1'b1) bad = 1'b1;
      if (dec_en) tx_seen.push_back({bad, d});
    end
    dec_prev = u1_txd;
  end

  task automatic tx_push(input logic [7:0] d);
    bit ok;
    ok = 0;
    u1_tx_data  = d;
    u1_tx_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (u1_tx_ready) ok = 1;
      step();
    end
    chk("tx_accept", 32'(ok), 1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 * n && got.size() < n; i++) step();
    chk("rx_count", got.size(), n);
  endtask

  task automatic serial_send(input logic [7:0] d, input logic stop_val, input logic flip);
    logic [7:0] v;
    v = d;
    drv_line = 1'b0;
    repeat (BC) step();
    for (int j = 0; j < 8; j++) begin
      drv_line = v[j];
      repeat (BC) step();
    end
    if (PEN == 1) begin
      drv_line = (^v) ^ flip;
      repeat (BC) step();
    end
    drv_line = stop_val;
    repeat (BC) step();
    drv_line = 1'b1;
    repeat (BC) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] r;
    int lat, cnt_low, cnt_rdy;
    bit ok;
    u1_tx_data = '0; u1_tx_valid = 0; u1_rx_ready = 1;
    u2_tx_data = '0; u2_tx_valid = 0; u2_rx_ready = 1;
    cts_force = 0; drv_en = 0; drv_line = 1;

    // Reset state
    repeat (3) step();
    chk("rst_txd", u1_txd, 1);
    chk("rst_rx_valid", u2_rx_valid, 0);
    chk("rst_rts", u2_rts, 1);
    chk("rst_rx_data", u2_rx_data, 0);
    chk("rst_flags", {u2_frame_err, u2_parity_err, u2_rx_overrun}, 0);
    chk("rst_tx_ready", u1_tx_ready, 1);
    rst_n = 1'b1;
    repeat (4) step();

    // Loopback: fixed back-to-back bytes
    got.delete(); acc.delete(); fall.delete(); rise.delete(); tx_seen.delete();
    exp_q = '{8'hFF, 8'hAA, 8'h33};
    foreach (exp_q[i]) tx_push(exp_q[i]);
    u1_tx_valid = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (u1_tx_ready) ok = 1; else step();
    end
    chk("ready_gap2", 32'(cyc - acc[2]), NB * BC);
    wait_rx(3);
    foreach (exp_q[i]) begin
      chk("loop_rx", got[i], {2'b00, exp_q[i]});
      chk("loop_txline", tx_seen[i], {1'b0, exp_q[i]});
    end
    chk("ready_gap0", 32'(acc[1] - acc[0]), NB * BC);
    chk("ready_gap1", 32'(acc[2] - acc[1]), NB * BC);
    chk("b2b_start_gap", 32'(fall[1] - fall[0]), NB * BC);
    lat = rise[0] - fall[0];
    chk("latency_window", 32'(lat >= (NB - 1) * BC + BC / 2 + 2 && lat <= (NB - 1) * BC + BC / 2 + 4), 1);

    // Loopback: random bytes with random idle gaps
    got.delete(); tx_seen.delete(); exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      r = 8'($urandom);
      exp_q.push_back(r);
      tx_push(r);
      u1_tx_valid = 0;
      repeat ($urandom_range(0, 15)) step();
    end
    wait_rx(6);
    foreach (exp_q[i]) begin
      chk("rand_rx", got[i], {2'b00, exp_q[i]});
      chk("rand_txline", tx_seen[i], {1'b0, exp_q[i]});
    end

    // Reverse direction u2 -> u1
    r = 8'($urandom);
    u2_tx_data = r; u2_tx_valid = 1; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (u2_tx_ready) ok = 1;
      step();
    end
    u2_tx_valid = 0;
    for (int i = 0; i < 300 && got1.size() < 1; i++) step();
    chk("rev_rx", got1[0], r);

    // Flow control
    got.delete(); ov_pulses = 0; ov_cycles = 0;
    u2_rx_ready = 0;
    tx_push(8'h55);
    u1_tx_valid = 0;
    for (int i = 0; i < 300 && !u2_rx_valid; i++) step();
    chk("fc_data", u2_rx_data, 8'h55);
    chk("fc_rts", u2_rts, 0);
    u1_tx_data = 8'h0F; u1_tx_valid = 1;
    cnt_low = 0; cnt_rdy = 0;
    repeat (100) begin
      @(negedge clk);
      if (!u1_txd) cnt_low++;
      if (u1_tx_ready) cnt_rdy++;
      step();
    end
    chk("fc_txd_idle", cnt_low, 0);
    chk("fc_tx_ready", cnt_rdy, 0);
    u2_rx_ready = 1;
    tx_push(8'h0F);
    u1_tx_valid = 0;
    wait_rx(2);
    chk("fc_first", got[0], {2'b00, 8'h55});
    chk("fc_second", got[1], {2'b00, 8'h0F});
    chk("fc_no_overrun", ov_pulses, 0);

    // Overrun with flow control bypassed
    got.delete(); ov_pulses = 0; ov_cycles = 0;
    cts_force = 1; u2_rx_ready = 0;
    tx_push(8'h12);
    tx_push(8'h34);
    u1_tx_valid = 0;
    for (int i = 0; i < 300 && ov_pulses == 0; i++) step();
    repeat (20) step();
    chk("ov_data", u2_rx_data, 8'h12);
    chk("ov_valid", u2_rx_valid, 1);
    chk("ov_pulses", ov_pulses, 1);
    chk("ov_width", ov_cycles, 1);
    u2_rx_ready = 1;
    repeat (5) step();
    chk("ov_popped", got.size(), 1);
    chk("ov_kept", got[0], {2'b00, 8'h12});
    cts_force = 0;

    // Glitch shorter than half a bit
    got.delete();
    drv_en = 1; drv_line = 1;
    repeat (5) step();
    drv_line = 0;
    repeat (3) step();
    drv_line = 1;
    repeat (40) step();
    chk("glitch_valid", u2_rx_valid, 0);
    chk("glitch_count", got.size(), 0);
    r = 8'($urandom);
    serial_send(r, 1'b1, 1'b0);
    wait_rx(1);
    chk("glitch_recover", got[0], {2'b00, r});

    // Framing error then a clean frame
    got.delete();
    serial_send(8'hA5, 1'b0, 1'b0);
    repeat (BC) step();
    r = 8'($urandom);
    serial_send(r, 1'b1, 1'b0);
    wait_rx(2);
    chk("frame_err_set", got[0], {2'b10, 8'hA5});
    chk("frame_err_clear", got[1], {2'b00, r});

`ifdef UART_PARITY_EN
    // Parity error then a clean frame
    got.delete();
    serial_send(8'h3C, 1'b1, 1'b1);
    serial_send(8'h3C, 1'b1, 1'b0);
    wait_rx(2);
    chk("parity_err_set", got[0], {2'b01, 8'h3C});
    chk("parity_err_clear", got[1], {2'b00, 8'h3C});
`endif
    drv_en = 0;

    // Reset in the middle of a frame
    dec_en = 0;
    tx_push(8'h00);
    u1_tx_valid = 0;
    repeat (30) step();
    chk("pre_reset_txd", u1_txd, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_txd_now", u1_txd, 1);
    chk("reset_rx_valid", u2_rx_valid, 0);
    step();
    rst_n = 1'b1;
    repeat (150) step();
    got.delete(); tx_seen.delete();
    dec_en = 1;
    repeat (2) step();
    r = 8'($urandom);
    tx_push(r);
    u1_tx_valid = 0;
    wait_rx(1);
    chk("post_reset_rx", got[0], {2'b00, r});
    repeat (10) step();
    chk("post_reset_txline", tx_seen[0], {1'b0, r});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
